cordic_core: RTL and testbench

- Iterative single-stage CORDIC engine; performs exactly one micro-rotation per controller step command on internal x/y/z registers.
- Supports circular and hyperbolic systems, each in rotation or vectoring mode.
- Driven by a software-style controller (sequencer/monitor) that loads initial values, issues N steps, reads results and overflow flags.
- No gain compensation: outputs carry the CORDIC gain (circular ≈1.64676, hyperbolic ≈0.82816).

---
 rtl/cordic_core.sv | 230 +++++++++++++++++++++++
 tb/tb_cordic_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_core.sv
// cordic_core: iterative single-stage CORDIC engine. One micro-rotation per step command,
// circular or hyperbolic system, rotation or vectoring mode, outputs carry the CORDIC gain.
module cordic_core #(
  parameter int p_WIDTH        = 32,
  parameter int p_HYP_INT_BITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic [p_WIDTH-1:0] i_z,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_system,
  input  logic               i_mode,
  output logic [p_WIDTH-1:0] o_x,
  output logic [p_WIDTH-1:0] o_y,
  output logic [p_WIDTH-1:0] o_z,
  output logic [5:0]         o_iter,
  output logic               o_x_ov,
  output logic               o_y_ov,
  output logic               o_z_ov
);

  localparam int MSB      = p_WIDTH - 1;
  localparam int KW       = $clog2(p_WIDTH);
  localparam int HYP_FRAC = p_WIDTH - 1 - p_HYP_INT_BITS;
  localparam int AC_L     = (p_WIDTH > 32) ? p_WIDTH - 32 : 0;
  localparam int AC_R     = (p_WIDTH < 32) ? 32 - p_WIDTH : 0;
  localparam int AH_L     = (HYP_FRAC > 28) ? HYP_FRAC - 28 : 0;
  localparam int AH_R     = (HYP_FRAC < 28) ? 28 - HYP_FRAC : 0;
  localparam logic [KW-1:0] K_MAX = KW'(p_WIDTH - 1);

  // Reference ROMs hold 32-bit-scale entries: circular 2^32 = one turn, hyperbolic Q3.28.
  function automatic logic [31:0] atan_ref(input logic [5:0] k);
    case (k)
      6'd0:  return 32'h20000000;
      6'd1:  return 32'h12E4051E;
      6'd2:  return 32'h09FB385B;
      6'd3:  return 32'h051111D4;
      6'd4:  return 32'h028B0D43;
      6'd5:  return 32'h0145D7E1;
      6'd6:  return 32'h00A2F61E;
      6'd7:  return 32'h00517C55;
      6'd8:  return 32'h0028BE53;
      6'd9:  return 32'h00145F2F;
      6'd10: return 32'h000A2F98;
      6'd11: return 32'h000517CC;
      6'd12: return 32'h00028BE6;
      6'd13: return 32'h000145F3;
      6'd14: return 32'h0000A2FA;
      6'd15: return 32'h0000517D;
      6'd16: return 32'h000028BE;
      6'd17: return 32'h0000145F;
      6'd18: return 32'h00000A30;
      6'd19: return 32'h00000518;
      6'd20: return 32'h0000028C;
      6'd21: return 32'h00000146;
      6'd22: return 32'h000000A3;
      6'd23: return 32'h00000051;
      6'd24: return 32'h00000029;
      6'd25: return 32'h00000014;
      6'd26: return 32'h0000000A;
      6'd27: return 32'h00000005;
      6'd28: return 32'h00000003;
      6'd29: return 32'h00000001;
      6'd30: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  // atanh(1) is unbounded, so k = 0 (only reachable by switching systems mid-run) rotates by 0.
  function automatic logic [31:0] atanh_ref(input logic [5:0] k);
    case (k)
      6'd1:  return 32'h08C9F53D;
      6'd2:  return 32'h04162BBF;
      6'd3:  return 32'h0202B124;
      6'd4:  return 32'h01005589;
      6'd5:  return 32'h00800AAC;
      6'd6:  return 32'h00400155;
      6'd7:  return 32'h0020002B;
      6'd8:  return 32'h00100005;
      6'd9:  return 32'h00080001;
      6'd10: return 32'h00040000;
      6'd11: return 32'h00020000;
      6'd12: return 32'h00010000;
      6'd13: return 32'h00008000;
      6'd14: return 32'h00004000;
      6'd15: return 32'h00002000;
      6'd16: return 32'h00001000;
      6'd17: return 32'h00000800;
      6'd18: return 32'h00000400;
      6'd19: return 32'h00000200;
      6'd20: return 32'h00000100;
      6'd21: return 32'h00000080;
      6'd22: return 32'h00000040;
      6'd23: return 32'h00000020;
      6'd24: return 32'h00000010;
      6'd25: return 32'h00000008;
      6'd26: return 32'h00000004;
      6'd27: return 32'h00000002;
      6'd28: return 32'h00000001;
      6'd29: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [p_WIDTH-1:0] rescale(input logic [31:0] r, input int sl, input int sr);
    logic [63:0] w;
    w = {32'd0, r} << sl;
    w = (w + ((64'd1 << sr) >> 1)) >> sr;
    return w[p_WIDTH-1:0];
  endfunction

  // Wrapping add/subtract; flag is true signed overflow of the operation performed.
  function automatic logic [p_WIDTH:0] addsub(input logic [p_WIDTH-1:0] a,
                                              input logic [p_WIDTH-1:0] b,
                                              input logic               sub);
    logic [p_WIDTH-1:0] s;
    logic               ov;
    if (sub) begin
      s  = a - b;
      ov = (a[MSB] != b[MSB]) && (s[MSB] != a[MSB]);
    end else begin
      s  = a + b;
      ov = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
    end
    return {ov, s};
  endfunction

  logic [p_WIDTH-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic [KW-1:0]      k_q, k_d;
  logic               rep_q, rep_d;
  logic [5:0]         iter_q, iter_d;
  logic               xov_q, yov_q, zov_q, xov_d, yov_d, zov_d;

  logic [5:0]         k6;
  logic               d_pos, rep_k;
  logic [p_WIDTH-1:0] x_sh, y_sh, ang;
  logic [p_WIDTH:0]   x_res, y_res, z_res;
  logic [KW-1:0]      k_inc;

  // Datapath and index sequencing for one micro-rotation.
  always_comb begin
    k6     = 6'(k_q);
    d_pos  = i_mode ? ~z_q[MSB] : y_q[MSB];
    x_sh   = $signed(x_q) >>> k_q;
    y_sh   = $signed(y_q) >>> k_q;
    ang    = i_system ? rescale(atan_ref(k6), AC_L, AC_R) : rescale(atanh_ref(k6), AH_L, AH_R);
    x_res  = addsub(x_q, y_sh, i_system ? d_pos : ~d_pos);
    y_res  = addsub(y_q, x_sh, ~d_pos);
    z_res  = addsub(z_q, ang, d_pos);
    k_inc  = (k_q == K_MAX) ? k_q : k_q + KW'(1);
    rep_k  = (k6 == 6'd4) || (k6 == 6'd13) || (k6 == 6'd40);

    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    k_d    = k_q;
    rep_d  = rep_q;
    iter_d = iter_q;
    xov_d  = xov_q;
    yov_d  = yov_q;
    zov_d  = zov_q;

    if (i_load) begin
      x_d    = i_x;
      y_d    = i_y;
      z_d    = i_z;
      k_d    = i_system ? KW'(0) : KW'(1);
      rep_d  = 1'b0;
      iter_d = 6'd0;
      xov_d  = 1'b0;
      yov_d  = 1'b0;
      zov_d  = 1'b0;
    end else if (i_step) begin
      x_d    = x_res[p_WIDTH-1:0];
      y_d    = y_res[p_WIDTH-1:0];
      z_d    = z_res[p_WIDTH-1:0];
      xov_d  = x_res[p_WIDTH];
      yov_d  = y_res[p_WIDTH];
      zov_d  = z_res[p_WIDTH];
      iter_d = (iter_q == 6'd63) ? iter_q : iter_q + 6'd1;
      if (!i_system && rep_k && !rep_q) begin
        k_d   = k_q;
        rep_d = 1'b1;
      end else begin
        k_d   = k_inc;
        rep_d = 1'b0;
      end
    end else begin
      x_d = x_q;
      k_d = k_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      k_q    <= '0;
      rep_q  <= 1'b0;
      iter_q <= 6'd0;
      xov_q  <= 1'b0;
      yov_q  <= 1'b0;
      zov_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      k_q    <= k_d;
      rep_q  <= rep_d;
      iter_q <= iter_d;
      xov_q  <= xov_d;
      yov_q  <= yov_d;
      zov_q  <= zov_d;
    end
  end

  assign o_x    = x_q;
  assign o_y    = y_q;
  assign o_z    = z_q;
  assign o_iter = iter_q;
  assign o_x_ov = xov_q;
  assign o_y_ov = yov_q;
  assign o_z_ov = zov_q;

endmodule

// File: tb/tb_cordic_core.sv
// tb_cordic_core: directed single-step vector table plus multi-step convergence,
// shift-sequence, saturation, priority and reset sequences for cordic_core.
module tb_cordic_core;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_x, i_y, i_z;
  logic        i_load, i_step, i_system, i_mode;
  logic [31:0] o_x, o_y, o_z;
  logic [5:0]  o_iter;
  logic        o_x_ov, o_y_ov, o_z_ov;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_core #(.p_WIDTH(32), .p_HYP_INT_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .i_x(i_x), .i_y(i_y), .i_z(i_z),
    .i_load(i_load), .i_step(i_step), .i_system(i_system), .i_mode(i_mode),
    .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_iter(o_iter),
    .o_x_ov(o_x_ov), .o_y_ov(o_y_ov), .o_z_ov(o_z_ov)
  );

  typedef struct {
    logic        sys;
    logic        mode;
    logic [31:0] x, y, z;
    logic [31:0] ex, ey, ez;
    logic [2:0]  eov;
  } vec_t;

  vec_t vecs [6];

  function automatic longint s32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint ac_exp(input int k);
    return longint'($atan($pow(2.0, -1.0 * k)) / (2.0 * PI) * $pow(2.0, 32.0));
  endfunction

  function automatic longint ah_exp(input int k);
    return longint'($atanh($pow(2.0, -1.0 * k)) * $pow(2.0, 28.0));
  endfunction

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp_v, input longint tol);
    checks++;
    if ((act - exp_v) > tol || (exp_v - act) > tol) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp_v, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic sys, input logic mode,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    i_system = sys; i_mode = mode;
    i_x = x; i_y = y; i_z = z;
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
  endtask

  task automatic do_steps(input int n);
    i_step = 1'b1;
    repeat (n) tick();
    i_step = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int     hyp_k [16];
    real    kc, kh, x0r;
    longint zold, x0;
    int     ks;

    hyp_k = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
    kc = 1.0;
    for (int k = 0; k < 30; k++) kc = kc * $sqrt(1.0 + $pow(2.0, -2.0 * k));
    kh = 1.0;
    for (int s = 0; s < 30; s++) begin
      ks = (s < 16) ? hyp_k[s] : s - 1;
      kh = kh * $sqrt(1.0 - $pow(2.0, -2.0 * ks));
    end

    vecs[0] = '{sys:1'b1, mode:1'b1, x:32'h7FFFFFFF, y:32'h7FFFFFFF, z:32'h00000000,
                ex:32'h00000000, ey:32'hFFFFFFFE, ez:32'hE0000000, eov:3'b010};
    vecs[1] = '{sys:1'b1, mode:1'b0, x:32'h10000000, y:32'hF0000000, z:32'h00000000,
                ex:32'h20000000, ey:32'h00000000, ez:32'hE0000000, eov:3'b000};
    vecs[2] = '{sys:1'b0, mode:1'b1, x:32'h10000000, y:32'h00000000, z:32'h08000000,
                ex:32'h10000000, ey:32'h08000000, ez:32'hFF360AC3, eov:3'b000};
    vecs[3] = '{sys:1'b0, mode:1'b0, x:32'h20000000, y:32'hFC000000, z:32'h00000000,
                ex:32'h1E000000, ey:32'h0C000000, ez:32'hF7360AC3, eov:3'b000};
    vecs[4] = '{sys:1'b1, mode:1'b1, x:32'h40000000, y:32'h40000000, z:32'h80000000,
                ex:32'h80000000, ey:32'h00000000, ez:32'hA0000000, eov:3'b100};
    vecs[5] = '{sys:1'b1, mode:1'b0, x:32'h00000000, y:32'h00000000, z:32'h7FFFFFFF,
                ex:32'h00000000, ey:32'h00000000, ez:32'h9FFFFFFF, eov:3'b001};

    rst = 1'b1; i_load = 1'b0; i_step = 1'b0; i_system = 1'b1; i_mode = 1'b1;
    i_x = 32'h0; i_y = 32'h0; i_z = 32'h0;
    #3;
    chk("rst_x", s32(o_x), 0, 0);
    chk("rst_y", s32(o_y), 0, 0);
    chk("rst_z", s32(o_z), 0, 0);
    chk("rst_iter", o_iter, 0, 0);
    chk("rst_ov", {o_x_ov, o_y_ov, o_z_ov}, 0, 0);
    #9 rst = 1'b0;
    tick();

    // single-step vector table
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].sys, vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].z);
      chk($sformatf("v%0d_load_x", i), s32(o_x), s32(vecs[i].x), 0);
      chk($sformatf("v%0d_load_ov", i), {o_x_ov, o_y_ov, o_z_ov}, 0, 0);
      chk($sformatf("v%0d_load_iter", i), o_iter, 0, 0);
      do_steps(1);
      chk($sformatf("v%0d_x", i), s32(o_x), s32(vecs[i].ex), 0);
      chk($sformatf("v%0d_y", i), s32(o_y), s32(vecs[i].ey), 0);
      chk($sformatf("v%0d_z", i), s32(o_z), s32(vecs[i].ez), 0);
      chk($sformatf("v%0d_ov", i), {o_x_ov, o_y_ov, o_z_ov}, vecs[i].eov, 0);
      chk($sformatf("v%0d_iter", i), o_iter, 1, 0);
      tick(); tick();
      chk($sformatf("v%0d_hold_y", i), s32(o_y), s32(vecs[i].ey), 0);
      chk($sformatf("v%0d_hold_ov", i), {o_x_ov, o_y_ov, o_z_ov}, vecs[i].eov, 0);
      chk($sformatf("v%0d_hold_iter", i), o_iter, 1, 0);
    end

    // circular rotation by 45 degrees, with per-step angle decrements k = 0..11
    do_load(1'b1, 1'b1, 32'h4DBA76D4, 32'h0, 32'h20000000);
    i_step = 1'b1;
    for (int s = 0; s < 30; s++) begin
      zold = s32(o_z);
      tick();
      if (s < 12) chk($sformatf("cr_dz%0d", s), labs(s32(o_z) - zold), ac_exp(s), 1);
    end
    i_step = 1'b0;
    chk("cr_x", s32(o_x), longint'(1304065748.0 * kc * $cos(PI / 4.0)), 64);
    chk("cr_y", s32(o_y), longint'(1304065748.0 * kc * $sin(PI / 4.0)), 64);
    chk("cr_z", s32(o_z), 0, 12);
    chk("cr_iter", o_iter, 30, 0);
    chk("cr_ov", {o_x_ov, o_y_ov, o_z_ov}, 0, 0);

    // circular vectoring
    do_load(1'b1, 1'b0, 32'h0, 32'h0CCCCCCD, 32'h0);
    do_steps(30);
    chk("cv_x", s32(o_x), longint'(214748365.0 * kc), 64);
    chk("cv_y", s32(o_y), 0, 64);
    chk("cv_z", s32(o_z), 64'sh40000000, 16);

    // hyperbolic rotation, Q3.28
    x0r = 1.2051364 * $pow(2.0, 28.0);
    x0  = longint'(x0r);
    do_load(1'b0, 1'b1, 32'(x0), 32'h0, 32'h08000000);
    do_steps(30);
    chk("hr_x", s32(o_x), longint'(x0 * kh * $cosh(0.5)), 128);
    chk("hr_y", s32(o_y), longint'(x0 * kh * $sinh(0.5)), 128);
    chk("hr_z", s32(o_z), 0, 27);

    // hyperbolic vectoring, checking the shift sequence repeats k = 4 and k = 13
    do_load(1'b0, 1'b0, 32'h10000000, 32'h08000000, 32'h0);
    i_step = 1'b1;
    for (int s = 0; s < 30; s++) begin
      zold = s32(o_z);
      tick();
      if (s < 16) chk($sformatf("hv_dz%0d", s), labs(s32(o_z) - zold), ah_exp(hyp_k[s]), 1);
    end
    i_step = 1'b0;
    chk("hv_x", s32(o_x), longint'($sqrt(0.75) * $pow(2.0, 28.0) * kh), 128);
    chk("hv_y", s32(o_y), 0, 128);
    chk("hv_z", s32(o_z), longint'($atanh(0.5) * $pow(2.0, 28.0)), 27);
    chk("hv_ov", {o_x_ov, o_y_ov, o_z_ov}, 0, 0);

    // load and step together: load wins
    i_system = 1'b1; i_mode = 1'b1;
    i_x = 32'h12345678; i_y = 32'h0; i_z = 32'h0;
    i_load = 1'b1; i_step = 1'b1;
    tick();
    i_load = 1'b0; i_step = 1'b0;
    chk("prio_x", s32(o_x), 64'sh12345678, 0);
    chk("prio_iter", o_iter, 0, 0);

    // iteration counter saturation
    do_steps(62);
    chk("sat_62", o_iter, 62, 0);
    do_steps(8);
    chk("sat_63", o_iter, 63, 0);

    // asynchronous reset mid-sequence, then a normal restart
    do_load(1'b1, 1'b1, 32'h10000000, 32'h0, 32'h0);
    do_steps(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", s32(o_x), 0, 0);
    chk("arst_z", s32(o_z), 0, 0);
    chk("arst_iter", o_iter, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_load(1'b1, 1'b1, 32'h10000000, 32'h0, 32'h0);
    do_steps(1);
    chk("restart_x", s32(o_x), 64'sh10000000, 0);
    chk("restart_y", s32(o_y), 64'sh10000000, 0);
    chk("restart_z", s32(o_z), s32(32'hE0000000), 0);
    chk("restart_iter", o_iter, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
